// File: rtl/lut_interp_pipe.sv
// lut_interp_pipe
//
// Pipelined piecewise-linear function evaluator. The input sample is split
// into a segment index (upper SEG_BITS bits) and a fraction (remaining
// FRAC_W bits). The two breakpoints bounding that segment are read from a
// runtime-writable LUT, and the output is linearly interpolated between them.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears pipeline and LUT)
//   in_valid   input sample valid
//   in_ready   block accepts a sample this cycle (pure function of output side)
//   in_data    input sample, IN_W bits
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   interpolated result, OUT_W bits
//   cfg_we     LUT write strobe
//   cfg_addr   breakpoint index 0..N (writes above N are dropped)
//   cfg_data   breakpoint value
//
// Build option:
//   LUT_INTERP_ROUND_EN  when defined, the final shift rounds half toward
//                        +inf instead of truncating toward -inf.

module lut_interp_pipe #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 8,
    parameter int SEG_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    input  logic                cfg_we,
    input  logic [SEG_BITS:0]   cfg_addr,
    input  logic [OUT_W-1:0]    cfg_data
);

    localparam int N      = 1 << SEG_BITS;
    localparam int FRAC_W = IN_W - SEG_BITS;
    localparam int P_W    = OUT_W + FRAC_W + 2;
    localparam logic [SEG_BITS:0] MAX_ADDR = (SEG_BITS+1)'(N);

    // N segments need N+1 breakpoints; entry N closes the top segment.
    logic [OUT_W-1:0] lut [0:N];

    logic                    en;
    logic [SEG_BITS-1:0]     seg;
    logic [FRAC_W-1:0]       frac;
    logic [SEG_BITS:0]       seg_lo;
    logic [SEG_BITS:0]       seg_hi;

    logic                    v1;
    logic [OUT_W-1:0]        f1_s1;
    logic [OUT_W-1:0]        f2_s1;
    logic [FRAC_W-1:0]       frac_s1;

    logic                    v2;
    logic [OUT_W-1:0]        f1_s2;
    logic signed [P_W-1:0]   prod_s2;

    logic signed [P_W-1:0]   diff_ext;
    logic signed [P_W-1:0]   frac_ext;
    logic signed [P_W-1:0]   p_adj;
    logic [OUT_W-1:0]        out_next;

    // The whole pipeline moves as one: it advances whenever the output
    // register is empty or being drained this cycle.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Segment index is widened by one bit before the +1 so the top segment
    // addresses the endpoint entry rather than wrapping to entry 0.
    assign seg    = in_data[IN_W-1:FRAC_W];
    assign frac   = in_data[FRAC_W-1:0];
    assign seg_lo = {1'b0, seg};
    assign seg_hi = seg_lo + (SEG_BITS+1)'(1);

    // Breakpoint storage. A write lands on the clock edge, so a sample read
    // in the same cycle still sees the previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= N; i++) begin
                lut[i] <= '0;
            end
        end else if (cfg_we && (cfg_addr <= MAX_ADDR)) begin
            lut[cfg_addr] <= cfg_data;
        end
    end

    // Stage 1: capture both breakpoints and the fraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            f1_s1   <= '0;
            f2_s1   <= '0;
            frac_s1 <= '0;
        end else if (en) begin
            v1      <= in_valid;
            f1_s1   <= lut[seg_lo];
            f2_s1   <= lut[seg_hi];
            frac_s1 <= frac;
        end
    end

    // Slope and fraction are zero-extended into a signed product-wide
    // container; the difference can be negative on a falling segment.
    assign diff_ext = $signed({{(FRAC_W+2){1'b0}}, f2_s1})
                    - $signed({{(FRAC_W+2){1'b0}}, f1_s1});
    assign frac_ext = $signed({{(OUT_W+2){1'b0}}, frac_s1});

    // Stage 2: multiply slope by fraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            f1_s2   <= '0;
            prod_s2 <= '0;
        end else if (en) begin
            v2      <= v1;
            f1_s2   <= f1_s1;
            prod_s2 <= diff_ext * frac_ext;
        end
    end

`ifdef LUT_INTERP_ROUND_EN
    // Adding half an LSB before the floor shift gives round-half-up.
    assign p_adj = prod_s2 + $signed(P_W'(1) << (FRAC_W-1));
`else
    assign p_adj = prod_s2;
`endif

    // The interpolated value lies between the two breakpoints, so only the
    // low OUT_W bits of the sum can be non-zero.
    assign out_next = f1_s2 + OUT_W'(p_adj >>> FRAC_W);

    // Stage 3: register the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= v2;
            out_data  <= out_next;
        end
    end

endmodule

// File: doc/lut_interp_pipe.md
Name: lut_interp_pipe

Overview:
- Parametrised, pipelined piecewise-linear function evaluator: the input word is split into a segment index (MSBs) and a fraction (LSBs), two adjacent breakpoints are read from a LUT, and the output is linearly interpolated between them.
- Successor to the team's combinational 64-slot interpolator, adding:
  - generic widths and segment count;
  - an endpoint breakpoint, so the top segment never wraps to entry 0;
  - a runtime-writable LUT;
  - a 3-stage pipeline with valid/ready flow control.
- Sits between a sample source and downstream datapath logic as a reusable function-approximation engine.

Parameters:
- IN_W, 8, input sample width.
- OUT_W, 8, breakpoint and output width (unsigned).
- SEG_BITS, 6, segment index bits. N = 2**SEG_BITS segments. FRAC_W = IN_W-SEG_BITS, which must be ≥1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  IN_W  input sample.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  interpolated result.
- cfg_we  in  1  LUT write strobe.
- cfg_addr  in  SEG_BITS+1  breakpoint index, 0..N.
- cfg_data  in  OUT_W  breakpoint value.

Behaviour:
- LUT storage
  - N+1 registers, entries 0..N.
  - Entry N is the endpoint for segment N-1.
  - Reset clears all entries to 0.
  - A write with cfg_addr > N is ignored.
  - A write is visible to any stage-1 read from the following cycle onward. Samples already past stage 1 keep the values they captured.
- Flow control
  - en = !out_valid || out_ready.
  - in_ready = en; this is combinational and does not depend on in_valid.
  - A transfer occurs when in_valid && in_ready, and likewise on the output side.
  - When en=0, all pipeline registers hold, including valid bits.
  - Full throughput: 1 sample per cycle when out_ready is held at 1.
- Pipeline; every stage advances only when en=1
  - S1: seg = in_data[IN_W-1:FRAC_W], frac = in_data[FRAC_W-1:0]. Register F1 = LUT[seg], F2 = LUT[seg+1], frac, and v1 = in_valid. seg+1 is computed at SEG_BITS+1 width, so seg = N-1 reads entry N and never wraps.
  - S2: d = F2 - F1 as a signed OUT_W+1 value. Register p = d * frac, signed, OUT_W+FRAC_W+2 bits wide. Register F1 and v2 = v1.
  - S3: out_data = F1 + (p >>> FRAC_W), using an arithmetic shift, so truncation is toward -inf. Register the result and set out_valid = v2.
- Latency: 3 cycles from accepted input to out_valid when there is no stall.
- Range: the result always lies between F1 and F2, so no saturation logic is needed. Any sum bits above OUT_W are zero by construction.
- Bubbles: in_valid=0 inserts a bubble. The data registers may update freely, but the valid bits carry 0.
- Reset
  - out_valid = 0, out_data = 0, all valid bits = 0, LUT = 0.
  - An assertion mid-stream drops every in-flight sample.
  - in_ready is 1 in the first cycle after release.
- Simultaneous events: cfg_we and an input transfer in the same cycle → the S1 read uses the old LUT contents.

Optional Feature:
- Macro: LUT_INTERP_ROUND_EN.
- Defined: S3 computes F1 + ((p + 2**(FRAC_W-1)) >>> FRAC_W), i.e. round half toward +inf.
- Undefined: truncation as described in Behaviour.
- Latency and handshake are identical in both builds.

Test Plan:
- Linear LUT, defaults: entry i = 4i for i<64, entry 64 = 255. Send in_data 133 → out_data 133 after 3 cycles. Send in_data 255 (seg 63, frac 3; F1=252, F2=255) → 254.
- Falling segment: entry 10 = 200, entry 11 = 100, in_data 41 → 175. Same value with and without the round macro.
- Rounding: entry 10 = 10, entry 11 = 16, in_data 43 → 14 without LUT_INTERP_ROUND_EN, 15 with it.
- Backpressure: stream 8 back-to-back samples with out_ready held 0 for cycles 4–7.
  - out_valid and out_data stay stable while stalled.
  - in_ready is 0 while stalled.
  - All 8 results arrive in order with no loss or duplication.
- Reconfiguration:
  - Write entry 5 = 77 in the same cycle that in_data 20 is accepted → the result uses the old entry 5.
  - The next sample with in_data 20 → 77.
  - A write to cfg_addr 100 changes nothing.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight → out_valid drops immediately, the LUT reads back 0, and no stale result appears after release.
